// File: rtl/min_row_feeder.sv
// Row feeder for the attention row-minimum path: packs eight 16-bit scores,
// holds start to the 8-lane minimum unit, and returns its result or a timeout.
module min_row_feeder #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] numbers,
  output logic         start,
  input  logic [15:0]  mu_result,
  input  logic         mu_done,
  output logic [15:0]  min_out,
  output logic         min_err,
  output logic         min_valid,
  input  logic         min_ready
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [CW-1:0] RCNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_r;
  logic [2:0]    wcnt_r;
  logic [CW-1:0] rcnt_r;

  assign in_ready = (state_r == FILL);

  // Row capture, minimum-unit handshake and result hold; everything is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FILL;
      wcnt_r    <= 3'd0;
      rcnt_r    <= '0;
      numbers   <= 128'd0;
      start     <= 1'b0;
      min_out   <= 16'd0;
      min_err   <= 1'b0;
      min_valid <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (in_valid) begin
            numbers[{wcnt_r, 4'd0} +: 16] <= in_data;
            wcnt_r <= wcnt_r + 3'd1;
            if (wcnt_r == 3'd7) begin
              state_r <= RUN;
              start   <= 1'b1;
              rcnt_r  <= '0;
            end
          end
        end
        RUN: begin
          // mu_done takes priority over the watchdog in the same cycle
          if (mu_done) begin
            min_out   <= mu_result;
            min_err   <= 1'b0;
            start     <= 1'b0;
            min_valid <= 1'b1;
            state_r   <= OUT;
          end else if (rcnt_r == RCNT_LAST) begin
            min_out   <= 16'hFFFF;
            min_err   <= 1'b1;
            start     <= 1'b0;
            min_valid <= 1'b1;
            state_r   <= OUT;
          end else begin
            rcnt_r <= rcnt_r + CW'(1);
          end
        end
        OUT: begin
          if (min_ready) begin
            min_valid <= 1'b0;
            rcnt_r    <= '0;
            state_r   <= FILL;
          end
        end
        default: begin
          state_r   <= FILL;
          wcnt_r    <= 3'd0;
          rcnt_r    <= '0;
          start     <= 1'b0;
          min_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_min_row_feeder.sv
// Directed bench for min_row_feeder with a behavioural minimum-unit stub.
module tb_min_row_feeder;

  logic         clk;
  logic         rst_n;
  logic [15:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] numbers;
  logic         start;
  logic [15:0]  mu_result;
  logic         mu_done;
  logic [15:0]  min_out;
  logic         min_err;
  logic         min_valid;
  logic         min_ready;

  int tests_run;
  int tests_failed;

  logic       mu_stuck;
  logic       force_done;
  logic [3:0] mu_cnt;
  logic [15:0] row_min_s;

  min_row_feeder #(.TIMEOUT(15), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .numbers(numbers), .start(start),
    .mu_result(mu_result), .mu_done(mu_done),
    .min_out(min_out), .min_err(min_err), .min_valid(min_valid), .min_ready(min_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub minimum unit: done 5 cycles after start rises, 6 when the minimum is zero
  always_comb begin
    row_min_s = numbers[15:0];
    for (int k = 1; k < 8; k++)
      if (numbers[16*k +: 16] < row_min_s) row_min_s = numbers[16*k +: 16];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mu_cnt <= 4'd0;
    else if (!start) mu_cnt <= 4'd0;
    else             mu_cnt <= mu_cnt + 4'd1;
  end

  assign mu_result = row_min_s;
  assign mu_done   = force_done |
                     (start && !mu_stuck && (mu_cnt == ((row_min_s == 16'd0) ? 4'd5 : 4'd4)));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives eight words starting at a negedge; returns at the negedge after word 7 is taken.
  task automatic feed_row(input logic [127:0] row, input int gap);
    for (int i = 0; i < 8; i++) begin
      check("start_low_during_fill", start, 1'b0);
      in_valid = 1'b1;
      in_data  = row[16*i +: 16];
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 7) repeat (gap) @(negedge clk);
    end
  endtask

  // Counts cycles start stays high, bounded so a hung DUT still reaches the summary.
  task automatic count_start(output int n);
    n = 0;
    while (start && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; in_data = 16'd0; in_valid = 1'b0; min_ready = 1'b1;
    mu_stuck = 1'b0; force_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_numbers", numbers, 128'd0);
    check("rst_start", start, 1'b0);
    check("rst_min_out", min_out, 16'd0);
    check("rst_min_err", min_err, 1'b0);
    check("rst_min_valid", min_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // mu_done outside RUN must be ignored
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("done_in_fill_valid", min_valid, 1'b0);
    check("done_in_fill_ready", in_ready, 1'b1);

    // Row 1: back-to-back, minimum 0x0003 in lane 3
    feed_row(128'h0021_0050_0100_7FFF_0003_0200_0013_0040, 0);
    check("r1_start_rise", start, 1'b1);
    check("r1_in_ready_run", in_ready, 1'b0);
    check("r1_lane3", numbers[63:48], 16'h0003);
    count_start(n);
    check("r1_start_len", n, 5);
    check("r1_valid", min_valid, 1'b1);
    check("r1_min_out", min_out, 16'h0003);
    check("r1_min_err", min_err, 1'b0);
    @(negedge clk);
    check("r1_valid_one_cycle", min_valid, 1'b0);
    check("r1_in_ready_back", in_ready, 1'b1);

    // Row 2: zero in lane 7 takes the slower path
    feed_row(128'h0000_0077_0066_0055_0044_0033_0022_0011, 0);
    count_start(n);
    check("r2_start_len", n, 6);
    check("r2_valid", min_valid, 1'b1);
    check("r2_min_out", min_out, 16'h0000);
    check("r2_min_err", min_err, 1'b0);
    @(negedge clk);

    // Row 3: stuck minimum unit, consumer stalled in OUT
    mu_stuck = 1'b1; min_ready = 1'b0;
    feed_row(128'h0008_0007_0006_0005_0004_0003_0002_0001, 0);
    count_start(n);
    check("to_start_len", n, 15);
    check("to_start", start, 1'b0);
    check("to_valid", min_valid, 1'b1);
    check("to_min_out", min_out, 16'hFFFF);
    check("to_min_err", min_err, 1'b1);
    mu_stuck = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_data  = 16'h1234;
      @(negedge clk);
      check("hold_valid", min_valid, 1'b1);
      check("hold_min_out", min_out, 16'hFFFF);
      check("hold_min_err", min_err, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_start", start, 1'b0);
    end
    in_valid = 1'b0;
    check("hold_numbers", numbers, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    min_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_low", min_valid, 1'b0);
    check("hs_in_ready", in_ready, 1'b1);

    // Row 4: clean restart after the timeout
    feed_row(128'h1000_2000_3000_4000_0ABC_5000_6000_7000, 0);
    count_start(n);
    check("r4_start_len", n, 5);
    check("r4_min_out", min_out, 16'h0ABC);
    check("r4_min_err", min_err, 1'b0);
    @(negedge clk);

    // Row 5: gapped input preserves lane order
    feed_row(128'h0101_0202_0303_0404_0505_0606_0005_0707, 2);
    check("gap_start", start, 1'b1);
    check("gap_numbers", numbers, 128'h0101_0202_0303_0404_0505_0606_0005_0707);
    count_start(n);
    check("gap_min_out", min_out, 16'h0005);
    @(negedge clk);

    // Row 6: reset three cycles into RUN
    feed_row(128'h1111_2222_3333_4444_5555_6666_7777_8888, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_start", start, 1'b0);
    check("mrst_numbers", numbers, 128'd0);
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_min_out", min_out, 16'd0);
    check("mrst_min_valid", min_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    feed_row(128'h00F0_00E0_00D0_0030_00B0_00A0_0090_0080, 0);
    count_start(n);
    check("post_rst_start_len", n, 5);
    check("post_rst_min_out", min_out, 16'h0030);
    check("post_rst_min_err", min_err, 1'b0);
    check("post_rst_valid", min_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
